blink_rx: RTL and testbench
===========================

Name: blink_rx

Overview:
- Receiving end of the board's blink/square-wave outputs.
- Samples an asynchronous toggling input and detects each toggle.
- Measures the half-period in clk cycles and checks it against a nominal frequency with tolerance.
- Reports lock and loss-of-signal.
- Used for self-test loopback of blink outputs and to qualify external 1 Hz references for the stopwatch.

Parameters:
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000: clk frequency.
- INPUT_CLOCK_FREQUENCY_IN_HZ, 1: nominal full-period frequency of blink_in. Nominal half-period NOM = BOARD/(2*INPUT), integer divide.
- TOLERANCE_PERCENT, 10: accepted interval window LO = NOM - NOM*TOL/100 to HI = NOM + NOM*TOL/100, inclusive, integer math.
- LOCK_COUNT, 4: consecutive in-window intervals required to assert locked.
- Derived localparams: TIMEOUT = 2*NOM; CW = clog2(TIMEOUT+1).

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- blink_in  in  1  asynchronous square-wave input.
- edge_tick  out  1  one-cycle pulse per accepted toggle (either polarity).
- half_period  out  CW  cycles between the last two accepted toggles.
- period_valid  out  1  half_period holds a measurement; level.
- in_window  out  1  last half_period was within LO..HI.
- locked  out  1  LOCK_COUNT consecutive in-window intervals seen.
- timeout  out  1  no toggle for TIMEOUT cycles; level.

Behaviour:
- Reset (rst=0, async): all outputs 0; sync flops, counter, lock counter and state cleared; state IDLE. Sync flops reset to 0; the first sampled 1 counts as a toggle.
- Input path: 2-flop synchronizer s1→s2, then history flop p.
  - Raw toggle when s2 != p.
  - blink_in change captured by s1 at clock edge k → edge_tick high for exactly the cycle after edge k+2.
  - Toggles closer than 1 cycle apart are not resolvable; no requirement.
- Interval counter cnt (CW bits):
  - Cleared to 0 on each toggle; otherwise +1 per cycle.
  - Saturates at TIMEOUT; never wraps.
  - Measured interval = cnt+1 at the toggle cycle, i.e. the number of clk edges between consecutive edge_tick pulses.
- States:
  - IDLE: waiting for the first toggle. On toggle → ARMED. half_period not updated.
  - ARMED: one toggle seen, measuring.
    - On toggle: capture half_period, period_valid=1, evaluate window → TRACK.
    - On cnt reaching TIMEOUT → IDLE.
  - TRACK: on each toggle, capture half_period and update in_window.
    - In window: lock counter +1, saturating at LOCK_COUNT. locked=1 when it equals LOCK_COUNT.
    - Out of window: lock counter=0, locked=0, stay TRACK.
    - On cnt reaching TIMEOUT → IDLE.
- Timeout entry (to IDLE):
  - Sets timeout=1 and clears period_valid, in_window, locked and the lock counter.
  - half_period retains its last value.
  - timeout clears on the next toggle, which moves to ARMED.
- Update timing: all outputs are registered. half_period, in_window and locked update in the same cycle edge_tick is high.
- Simultaneous toggle and cnt==TIMEOUT: the toggle wins. Interval = TIMEOUT+1 is captured as out-of-window; no timeout is asserted.
- Reset mid-measurement: immediate return to IDLE with all outputs 0; no partial measurement is reported.

Optional Feature:
- Macro: BLINK_RX_GLITCH_FILTER_EN.
- When defined:
  - Adds parameter FILTER_CYCLES (default 3).
  - s2 must hold a new value for FILTER_CYCLES consecutive cycles before it is accepted into p.
  - Shorter pulses are discarded entirely: no edge_tick and cnt is not cleared.
  - Adds FILTER_CYCLES-1 cycles of latency to edge_tick; measured intervals are unchanged for clean input.
- When undefined: raw synchronizer output is used, with latency as stated above.

Test Plan:
- All scenarios use BOARD=1000, INPUT=10 → NOM=50, LO=45, HI=55, TIMEOUT=100, LOCK_COUNT=4.
- Reset: hold rst=0 with blink_in toggling → all outputs 0. Release → state IDLE, no edge_tick until the first toggle.
- Nominal lock: toggle blink_in every 50 cycles for 6 toggles.
  - edge_tick fires 6 times, 50 cycles apart, starting 3 clk edges after the first change.
  - From the 2nd toggle: half_period=50, period_valid=1, in_window=1.
  - locked=1 coinciding with the 5th edge_tick.
- Window boundaries: toggle intervals 45, 55, 44, 56.
  - in_window = 1, 1, 0, 0.
  - locked drops to 0 at the 44-cycle interval and the lock counter restarts.
- Loss of signal: while locked, stop toggling.
  - 100 cycles after the last edge_tick: timeout=1, locked=0, period_valid=0, half_period still 50.
  - Next toggle → timeout=0, edge_tick=1, period_valid stays 0 until the following toggle.
- Collision and reset: arrange a toggle landing exactly when cnt==100.
  - half_period=101, in_window=0, timeout stays 0.
  - Then pull rst=0 mid-interval → all outputs 0 asynchronously, before the next clk edge.
- Glitch filter (macro defined, FILTER_CYCLES=3): inject 2-cycle pulses between nominal toggles.
  - No extra edge_tick; half_period stays 50.
  - A 3-cycle pulse is accepted as two toggles.

Source files
------------

// File: rtl/blink_rx.sv
// Receiver for blink/square-wave inputs: synchronizes, detects toggles, measures half-period, reports lock/LOS.
// Optional glitch filter enabled by defining BLINK_RX_GLITCH_FILTER_EN.
module blink_rx #(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned INPUT_CLOCK_FREQUENCY_IN_HZ = 1,
  parameter int unsigned TOLERANCE_PERCENT           = 10,
  parameter int unsigned LOCK_COUNT                  = 4,
`ifdef BLINK_RX_GLITCH_FILTER_EN
  parameter int unsigned FILTER_CYCLES               = 3,
`endif
  localparam int unsigned NOM     = BOARD_CLOCK_FREQUENCY_IN_HZ / (2 * INPUT_CLOCK_FREQUENCY_IN_HZ),
  localparam int unsigned TIMEOUT = 2 * NOM,
  localparam int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blink_in,
  output logic          edge_tick,
  output logic [CW-1:0] half_period,
  output logic          period_valid,
  output logic          in_window,
  output logic          locked,
  output logic          timeout
);

  localparam int unsigned LO = NOM - (NOM * TOLERANCE_PERCENT) / 100;
  localparam int unsigned HI = NOM + (NOM * TOLERANCE_PERCENT) / 100;
  localparam int unsigned LW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  state_t          r_state, w_state_nx;
  logic            r_s1, r_s2, r_p;
  logic            w_toggle;
  logic [CW-1:0]   r_cnt;
  logic            w_cnt_sat;
  logic [CW:0]     w_interval;
  logic [CW-1:0]   w_hp_meas;
  logic            w_in_win;
  logic [LW-1:0]   r_lock_cnt, w_lock_cnt_nx;
  logic            r_tick, w_tick_nx;
  logic [CW-1:0]   r_hp, w_hp_nx;
  logic            r_pv, w_pv_nx;
  logic            r_inw, w_inw_nx;
  logic            r_locked, w_locked_nx;
  logic            r_timeout, w_timeout_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= blink_in;
      r_s2 <= r_s1;
    end
  end

`ifdef BLINK_RX_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  logic [FW-1:0] r_flt;
  logic          w_diff;

  // A new level must persist FILTER_CYCLES samples before it becomes the accepted level.
  assign w_diff   = (r_s2 != r_p);
  assign w_toggle = w_diff && (r_flt == FW'(FILTER_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flt <= '0;
      r_p   <= 1'b0;
    end else begin
      if (!w_diff || w_toggle) r_flt <= '0;
      else                     r_flt <= r_flt + 1'b1;
      if (w_toggle) r_p <= r_s2;
    end
  end
`else
  assign w_toggle = (r_s2 != r_p);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_p <= 1'b0;
    else      r_p <= r_s2;
  end
`endif

  assign w_cnt_sat  = (r_cnt == CW'(TIMEOUT));
  assign w_interval = {1'b0, r_cnt} + 1'b1;
  assign w_hp_meas  = w_interval[CW] ? '1 : w_interval[CW-1:0];
  assign w_in_win   = (w_interval >= (CW+1)'(LO)) && (w_interval <= (CW+1)'(HI));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_cnt <= '0;
    else if (w_toggle)   r_cnt <= '0;
    else if (!w_cnt_sat) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_tick     <= 1'b0;
      r_hp       <= '0;
      r_pv       <= 1'b0;
      r_inw      <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_lock_cnt <= w_lock_cnt_nx;
      r_tick     <= w_tick_nx;
      r_hp       <= w_hp_nx;
      r_pv       <= w_pv_nx;
      r_inw      <= w_inw_nx;
      r_locked   <= w_locked_nx;
      r_timeout  <= w_timeout_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_lock_cnt_nx = r_lock_cnt;
    w_tick_nx     = w_toggle;
    w_hp_nx       = r_hp;
    w_pv_nx       = r_pv;
    w_inw_nx      = r_inw;
    w_locked_nx   = r_locked;
    w_timeout_nx  = r_timeout;
    case (r_state)
      IDLE: begin
        if (w_toggle) begin
          w_state_nx   = ARMED;
          w_timeout_nx = 1'b0;
        end
      end
      ARMED, TRACK: begin
        // A toggle coinciding with counter saturation is measured, not timed out.
        if (w_toggle) begin
          w_state_nx   = TRACK;
          w_hp_nx      = w_hp_meas;
          w_pv_nx      = 1'b1;
          w_inw_nx     = w_in_win;
          w_timeout_nx = 1'b0;
          if (w_in_win) begin
            if (r_lock_cnt != LW'(LOCK_COUNT)) w_lock_cnt_nx = r_lock_cnt + 1'b1;
            w_locked_nx = (w_lock_cnt_nx == LW'(LOCK_COUNT));
          end else begin
            w_lock_cnt_nx = '0;
            w_locked_nx   = 1'b0;
          end
        end else if (w_cnt_sat) begin
          w_state_nx    = IDLE;
          w_timeout_nx  = 1'b1;
          w_pv_nx       = 1'b0;
          w_inw_nx      = 1'b0;
          w_locked_nx   = 1'b0;
          w_lock_cnt_nx = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign edge_tick    = r_tick;
  assign half_period  = r_hp;
  assign period_valid = r_pv;
  assign in_window    = r_inw;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_blink_rx.sv
// Self-checking bench for blink_rx: directed scenarios plus randomized toggling against a timing-based model.
module tb_blink_rx;

  localparam int unsigned BOARD = 1000;
  localparam int unsigned INPUT = 10;
  localparam int unsigned TOL   = 10;
  localparam int unsigned LOCKN = 4;
  localparam int unsigned NOM   = BOARD / (2 * INPUT);
  localparam int unsigned LO    = NOM - NOM * TOL / 100;
  localparam int unsigned HI    = NOM + NOM * TOL / 100;
  localparam int unsigned TMO   = 2 * NOM;
  localparam int unsigned CW    = $clog2(TMO + 1);
`ifdef BLINK_RX_GLITCH_FILTER_EN
  localparam int F = 3;
`else
  localparam int F = 1;
`endif
  localparam int LAT = 2 + F;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          blink_in = 1'b0;
  logic          edge_tick;
  logic [CW-1:0] half_period;
  logic          period_valid, in_window, locked, timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;

  blink_rx #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(BOARD),
    .INPUT_CLOCK_FREQUENCY_IN_HZ(INPUT),
    .TOLERANCE_PERCENT(TOL),
`ifdef BLINK_RX_GLITCH_FILTER_EN
    .FILTER_CYCLES(3),
`endif
    .LOCK_COUNT(LOCKN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .blink_in(blink_in),
    .edge_tick(edge_tick),
    .half_period(half_period),
    .period_valid(period_valid),
    .in_window(in_window),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks clock-edge index of each accepted input transition and derives outputs from the gaps.
  bit hist[0:15];
  bit m_plev = 1'b0;
  bit m_have = 1'b0;
  int m_n = 0, m_last = 0, m_run = 0;
  bit m_tick = 1'b0, m_pv = 1'b0, m_inw = 1'b0, m_locked = 1'b0, m_to = 1'b0;
  int m_hp = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 16; j++) hist[j] = 1'b0;
      m_plev = 0; m_have = 0; m_n = 0; m_last = 0; m_run = 0;
      m_tick = 0; m_pv = 0; m_inw = 0; m_locked = 0; m_to = 0; m_hp = 0;
    end else begin
      bit acc;
      int iv;
      for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = blink_in;
      m_n++;
      acc = 1'b1;
      for (int j = 0; j < F; j++) if (hist[2+j] == m_plev) acc = 1'b0;
      m_tick = acc;
      if (acc) begin
        m_plev = ~m_plev;
        if (m_have) begin
          iv     = m_n - m_last;
          m_hp   = (iv > (2**CW - 1)) ? (2**CW - 1) : iv;
          m_pv   = 1'b1;
          m_inw  = (iv >= LO) && (iv <= HI);
          m_run  = m_inw ? m_run + 1 : 0;
          m_locked = (m_run >= LOCKN);
        end
        m_to   = 1'b0;
        m_have = 1'b1;
        m_last = m_n;
      end else if (m_have && (m_n - m_last == TMO + 1)) begin
        m_to = 1'b1; m_pv = 0; m_inw = 0; m_locked = 0; m_run = 0; m_have = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (edge_tick) n_ticks++;
    check("cyc_edge_tick",    edge_tick,        m_tick);
    check("cyc_half_period",  int'(half_period), m_hp);
    check("cyc_period_valid", period_valid,     m_pv);
    check("cyc_in_window",    in_window,        m_inw);
    check("cyc_locked",       locked,           m_locked);
    check("cyc_timeout",      timeout,          m_to);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, edge_tick, 0);
    check({tag, "_hp"},   int'(half_period), 0);
    check({tag, "_pv"},   period_valid, 0);
    check({tag, "_inw"},  in_window, 0);
    check({tag, "_lock"}, locked, 0);
    check({tag, "_to"},   timeout, 0);
  endtask

  // Waits w falling edges, flips the input, then waits until the tick should be visible.
  task automatic pulse(input int w);
    repeat (w) @(negedge clk);
    blink_in = ~blink_in;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    int t0, gap, g, a;
    int bnd[7];
    bnd = '{44, 45, 55, 56, 100, 101, 102};

    // Reset held with input activity
    repeat (6) begin
      @(negedge clk);
      blink_in = ~blink_in;
    end
    check_all_zero("rst_hold");
    @(negedge clk) blink_in = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_tick", n_ticks, 0);

    // Nominal lock
    pulse(10);
    check("first_tick_latency", edge_tick, 1);
    check("first_pv", period_valid, 0);
    for (int i = 2; i <= 6; i++) begin
      pulse(NOM - LAT);
      check("nom_tick", edge_tick, 1);
      check("nom_hp", int'(half_period), 50);
      check("nom_pv", period_valid, 1);
      check("nom_inw", in_window, 1);
      check("nom_locked", locked, (i >= 5) ? 1 : 0);
    end

    // Window boundaries
    pulse(45 - LAT); check("win45_inw", in_window, 1); check("win45_lock", locked, 1);
    pulse(55 - LAT); check("win55_inw", in_window, 1); check("win55_lock", locked, 1);
    pulse(44 - LAT); check("win44_inw", in_window, 0); check("win44_lock", locked, 0);
    check("win44_hp", int'(half_period), 44);
    pulse(56 - LAT); check("win56_inw", in_window, 0); check("win56_lock", locked, 0);
    for (int i = 1; i <= 4; i++) begin
      pulse(NOM - LAT);
      check("relock", locked, (i == 4) ? 1 : 0);
    end

    // Loss of signal
    repeat (100) @(negedge clk);
    check("los_before", timeout, 0);
    @(negedge clk);
    check("los_timeout", timeout, 1);
    check("los_locked", locked, 0);
    check("los_pv", period_valid, 0);
    check("los_hp_kept", int'(half_period), 50);
    pulse(20);
    check("los_recover_to", timeout, 0);
    check("los_recover_tick", edge_tick, 1);
    check("los_recover_pv", period_valid, 0);
    pulse(NOM - LAT);
    check("los_remeasure_pv", period_valid, 1);
    check("los_remeasure_hp", int'(half_period), 50);

    // Toggle colliding with counter saturation
    pulse(101 - LAT);
    check("coll_hp", int'(half_period), 101);
    check("coll_inw", in_window, 0);
    check("coll_to", timeout, 0);
    check("coll_tick", edge_tick, 1);
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk) blink_in = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

`ifdef BLINK_RX_GLITCH_FILTER_EN
    pulse(30);
    pulse(NOM - LAT);
    for (int i = 0; i < 3; i++) begin
      t0 = n_ticks;
      repeat (20) @(negedge clk);
      blink_in = ~blink_in;
      repeat (2) @(negedge clk);
      blink_in = ~blink_in;
      repeat (NOM - LAT - 22) @(negedge clk);
      blink_in = ~blink_in;
      repeat (LAT) @(negedge clk);
      check("glitch_hp", int'(half_period), 50);
      repeat (2) @(negedge clk);
      check("glitch_no_extra_tick", n_ticks, t0 + 1);
    end
    t0 = n_ticks;
    repeat (20) @(negedge clk);
    blink_in = ~blink_in;
    repeat (3) @(negedge clk);
    blink_in = ~blink_in;
    repeat (30) @(negedge clk);
    check("pulse3_two_ticks", n_ticks, t0 + 2);
`endif

    // Randomized intervals, boundary values and short glitches
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) gap = bnd[$urandom_range(0, 6)];
      else                           gap = $urandom_range(LAT + 8, 115);
      if ($urandom_range(0, 4) == 0) begin
        g = $urandom_range(1, 2);
        a = (gap - LAT) / 2;
        repeat (a) @(negedge clk);
        blink_in = ~blink_in;
        repeat (g) @(negedge clk);
        blink_in = ~blink_in;
        pulse(gap - LAT - a - g);
      end else begin
        pulse(gap - LAT);
      end
    end
    repeat (150) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
